// File: rtl/fetch_unit.sv
// fetch_unit: MSP430 instruction fetch stage. Walks the ROM one word per cycle,
// gathers the opcode plus up to two extension words, and hands the complete
// bundle to the decoder over a valid/ready handshake. Owns the program counter.
module fetch_unit #(
    parameter logic [15:0] RESET_VECTOR = 16'hFFFE,
    parameter bit          USE_VECTOR   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] rom_addr,
    output logic        rom_bw,
    input  logic [15:0] rom_out,
    input  logic        redirect_en,
    input  logic [15:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr_word,
    output logic [15:0] instr_ext1,
    output logic [15:0] instr_ext2,
    output logic [1:0]  instr_nx,
    output logic [15:0] instr_pc,
    output logic [15:0] next_pc
);

    typedef enum logic [2:0] {
        ST_VEC,
        ST_OP,
        ST_EXT1,
        ST_EXT2,
        ST_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] word_q, word_d;
    logic [15:0] ext1_q, ext1_d;
    logic [15:0] ext2_q, ext2_d;
    logic [1:0]  nx_q, nx_d;
    logic [15:0] ipc_q, ipc_d;
    logic        valid_q, valid_d;

    // Source operand needs an extension word for indexed/absolute/symbolic
    // (As=01, except R3 which is a constant generator) and for immediate (@PC+).
    // R2 with As=10/11 and R3 in every mode are constant generators.
    function automatic logic src_needs_ext(input logic [1:0] as_m, input logic [3:0] rs);
        return ((as_m == 2'b01) && (rs != 4'd3)) || ((as_m == 2'b11) && (rs == 4'd0));
    endfunction

    // Number of extension words following an opcode.
    function automatic logic [1:0] ext_count(input logic [15:0] op);
        logic [1:0] n;
        n = 2'd0;
        if (op[15:12] >= 4'h4) begin
            // Double-operand: source ext first, then destination ext when Ad=1
            n = {1'b0, src_needs_ext(op[5:4], op[11:8])} + {1'b0, op[7]};
        end else if (op[15:10] == 6'b000100) begin
            // Single-operand: the only operand is encoded in the source fields
            n = {1'b0, src_needs_ext(op[5:4], op[3:0])};
        end
        return n;
    endfunction

    assign rom_addr    = pc_q;
    assign rom_bw      = 1'b0;
    assign instr_valid = valid_q;
    assign instr_word  = word_q;
    assign instr_ext1  = ext1_q;
    assign instr_ext2  = ext2_q;
    assign instr_nx    = nx_q;
    assign instr_pc    = ipc_q;
    assign next_pc     = valid_q ? pc_q : 16'h0000;

    // Next-state: fetch sequencing, PC update, bundle capture and redirect.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        word_d  = word_q;
        ext1_d  = ext1_q;
        ext2_d  = ext2_q;
        nx_d    = nx_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;

        if (redirect_en && (state_q != ST_VEC)) begin
            // Redirect wins over everything; any partial bundle is dropped,
            // and a bundle handshaken this same cycle is already consumed.
            pc_d    = redirect_pc & 16'hFFFE;
            state_d = ST_OP;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_VEC: begin
                    pc_d    = rom_out & 16'hFFFE;
                    state_d = ST_OP;
                end
                ST_OP: begin
                    word_d  = rom_out;
                    ipc_d   = pc_q;
                    pc_d    = pc_q + 16'd2;
                    ext1_d  = 16'h0000;
                    ext2_d  = 16'h0000;
                    nx_d    = ext_count(rom_out);
                    if (ext_count(rom_out) == 2'd0) begin
                        state_d = ST_HOLD;
                        valid_d = 1'b1;
                    end else begin
                        state_d = ST_EXT1;
                    end
                end
                ST_EXT1: begin
                    ext1_d = rom_out;
                    pc_d   = pc_q + 16'd2;
                    if (nx_q == 2'd2) begin
                        state_d = ST_EXT2;
                    end else begin
                        state_d = ST_HOLD;
                        valid_d = 1'b1;
                    end
                end
                ST_EXT2: begin
                    ext2_d  = rom_out;
                    pc_d    = pc_q + 16'd2;
                    state_d = ST_HOLD;
                    valid_d = 1'b1;
                end
                ST_HOLD: begin
                    if (valid_q && instr_ready) begin
                        state_d = ST_OP;
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_OP;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs; reset clears the bundle and restarts fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= USE_VECTOR ? ST_VEC : ST_OP;
            pc_q    <= RESET_VECTOR;
            word_q  <= 16'h0000;
            ext1_q  <= 16'h0000;
            ext2_q  <= 16'h0000;
            nx_q    <= 2'd0;
            ipc_q   <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            word_q  <= word_d;
            ext1_q  <= ext1_d;
            ext2_q  <= ext2_d;
            nx_q    <= nx_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
        end
    end

endmodule
